// File: rtl/adaptive_rtg_controller.sv
// Adaptive random test generation sequencer: LFSR vectors are walked through the
// fault list via an inject handshake and accepted against an adaptive threshold.
module adaptive_rtg_controller #(
    parameter int unsigned NUM_FAULTS = 16,
    parameter int unsigned VEC_W      = 6,
    parameter int unsigned INIT_EXP   = 5,
    parameter int unsigned UT_LIMIT   = 13,
    parameter int unsigned COV_TARGET = 95,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned FIDX_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  test_vec,
    output logic [FIDX_W-1:0] flt_idx,
    output logic              inj_req,
    input  logic              inj_ack,
    input  logic              mismatch,
    output logic              acc_valid,
    output logic [VEC_W-1:0]  acc_vec,
    output logic [7:0]        acc_num,
    output logic [FIDX_W-1:0] det_count,
    output logic [6:0]        coverage,
    output logic [7:0]        trials
);

    localparam int unsigned EXP_W = FIDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_REQ, S_GAP, S_UPDATE, S_CHECK, S_DONE
    } state_t;

    state_t                  r_state;
    logic [15:0]             r_lfsr;
    logic [NUM_FAULTS-1:0]   r_ct_list;
    logic [NUM_FAULTS-1:0]   r_at_list;
    logic [FIDX_W-1:0]       r_ct_cnt;
    logic [FIDX_W-1:0]       r_new_cnt;
    logic [EXP_W-1:0]        r_exp;
    logic [7:0]              r_ut;
    logic                    r_busy;
    logic                    r_done;
    logic [VEC_W-1:0]        r_test_vec;
    logic [FIDX_W-1:0]       r_flt_idx;
    logic                    r_inj_req;
    logic                    r_acc_valid;
    logic [VEC_W-1:0]        r_acc_vec;
    logic [7:0]              r_acc_num;
    logic [FIDX_W-1:0]       r_det_count;
    logic [6:0]              r_coverage;

    logic [15:0]             w_lfsr_next;
    logic [NUM_FAULTS-1:0]   w_fmask;
    logic [NUM_FAULTS-1:0]   w_merged;
    logic [EXP_W:0]          w_exp_sum;
    logic [EXP_W-1:0]        w_exp_next;
    logic                    w_accept;
    logic [FIDX_W-1:0]       w_det_next;
    logic [6:0]              w_cov;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // One-hot for fault index 1..NUM_FAULTS mapped onto bit 0..NUM_FAULTS-1
    assign w_fmask  = NUM_FAULTS'(1) << (r_flt_idx - FIDX_W'(1));
    assign w_merged = r_at_list | r_ct_list;

    assign w_exp_sum  = (EXP_W+1)'(r_ct_cnt) + (EXP_W+1)'(r_exp);
    assign w_exp_next = (EXP_W'(r_ct_cnt) < r_exp) ? (r_exp >> 1) : EXP_W'(w_exp_sum >> 1);
    assign w_accept   = (EXP_W'(r_ct_cnt) >= w_exp_next) && (r_new_cnt != '0);

    assign w_cov = 7'((32'(r_det_count) * 32'd100) / NUM_FAULTS);

    always_comb begin
        w_det_next = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            w_det_next = w_det_next + FIDX_W'(w_merged[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_ct_list   <= '0;
            r_at_list   <= '0;
            r_ct_cnt    <= '0;
            r_new_cnt   <= '0;
            r_exp       <= EXP_W'(INIT_EXP);
            r_ut        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_test_vec  <= '0;
            r_flt_idx   <= '0;
            r_inj_req   <= 1'b0;
            r_acc_valid <= 1'b0;
            r_acc_vec   <= '0;
            r_acc_num   <= '0;
            r_det_count <= '0;
            r_coverage  <= '0;
        end else begin
            r_acc_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_at_list   <= '0;
                        r_det_count <= '0;
                        r_coverage  <= '0;
                        r_ut        <= '0;
                        r_exp       <= EXP_W'(INIT_EXP);
                        r_lfsr      <= LFSR_SEED;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_lfsr     <= w_lfsr_next;
                    r_test_vec <= w_lfsr_next[VEC_W-1:0];
                    r_ut       <= r_ut + 8'd1;
                    r_ct_list  <= '0;
                    r_ct_cnt   <= '0;
                    r_new_cnt  <= '0;
                    r_flt_idx  <= FIDX_W'(1);
                    r_inj_req  <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    if (inj_ack) begin
                        r_inj_req <= 1'b0;
                        if (mismatch) begin
                            r_ct_list <= r_ct_list | w_fmask;
                            r_ct_cnt  <= r_ct_cnt + FIDX_W'(1);
                            if ((r_at_list & w_fmask) == '0) begin
                                r_new_cnt <= r_new_cnt + FIDX_W'(1);
                            end
                        end
                        r_state <= (r_flt_idx == FIDX_W'(NUM_FAULTS)) ? S_UPDATE : S_GAP;
                    end
                end
                S_GAP: begin
                    r_flt_idx <= r_flt_idx + FIDX_W'(1);
                    r_inj_req <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_UPDATE: begin
                    // Acceptance is judged against the freshly updated threshold
                    r_exp <= w_exp_next;
                    if (w_accept) begin
                        r_at_list   <= w_merged;
                        r_det_count <= w_det_next;
                        r_acc_valid <= 1'b1;
                        r_acc_vec   <= r_test_vec;
                        r_acc_num   <= r_ut;
                    end
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_coverage <= w_cov;
                    if ((w_cov >= 7'(COV_TARGET)) || (r_ut >= 8'(UT_LIMIT))) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_GEN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign test_vec  = r_test_vec;
    assign flt_idx   = r_flt_idx;
    assign inj_req   = r_inj_req;
    assign acc_valid = r_acc_valid;
    assign acc_vec   = r_acc_vec;
    assign acc_num   = r_acc_num;
    assign det_count = r_det_count;
    assign coverage  = r_coverage;
    assign trials    = r_ut;

endmodule

// File: tb/tb_adaptive_rtg_controller.sv
// Bench for adaptive_rtg_controller: fault-sim responder with configurable ack latency
// plus a trial-level reference model of vector generation and acceptance.
module tb_adaptive_rtg_controller;

    localparam int unsigned NF = 16;
    localparam int unsigned VW = 6;
    localparam int unsigned IE = 5;
    localparam int unsigned UL = 13;
    localparam int unsigned CT = 95;
    localparam int unsigned FW = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stray = 1'b0;
    logic          inj_ack, mismatch;
    logic          busy, done, inj_req, acc_valid;
    logic [VW-1:0] test_vec, acc_vec;
    logic [FW-1:0] flt_idx, det_count;
    logic [7:0]    acc_num, trials;
    logic [6:0]    coverage;

    int n_pass = 0, n_total = 0;
    int mode = 1, lat = 0, wcnt = 0, cyc = 0;
    logic [NF:1] mis_tab [0:63];

    int m_vec[$], m_acc_vec[$], m_acc_num[$], m_acc_det[$], m_acc_cov[$];
    int m_trials, m_det, m_cov;
    int o_vec[$], o_acc_vec[$], o_acc_num[$], o_acc_det[$], o_acc_cov[$], o_len[$];
    int stab_viol = 0, gap_viol = 0, seq_viol = 0;

    logic          prev_req = 1'b0;
    logic [VW-1:0] prev_vec = '0;
    logic [FW-1:0] prev_fi = '0;
    int            prev_idx = 0, low_run = 0, last_t1 = -1;
    bit            acc_pend = 1'b0;

    always #5 clk = ~clk;

    adaptive_rtg_controller #(
        .NUM_FAULTS(NF), .VEC_W(VW), .INIT_EXP(IE), .UT_LIMIT(UL),
        .COV_TARGET(CT), .LFSR_SEED(SEED), .FIDX_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .test_vec(test_vec), .flt_idx(flt_idx), .inj_req(inj_req),
        .inj_ack(inj_ack), .mismatch(mismatch), .acc_valid(acc_valid),
        .acc_vec(acc_vec), .acc_num(acc_num), .det_count(det_count),
        .coverage(coverage), .trials(trials)
    );

    // Which faults a given vector exposes, per responder personality
    function automatic logic resp(input int md, input logic [VW-1:0] v, input int f);
        if (f < 1 || f > int'(NF)) return 1'b0;
        case (md)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (f == 1);
            default: return mis_tab[v][f];
        endcase
    endfunction

    assign inj_ack  = stray | (inj_req & (wcnt >= lat));
    assign mismatch = stray | resp(mode, test_vec, int'(flt_idx));

    always @(posedge clk) begin
        wcnt <= (!inj_req || inj_ack) ? 0 : wcnt + 1;
        cyc  <= cyc + 1;
    end

    // Protocol monitor and scoreboard capture
    always @(negedge clk) begin
        if (rst || !busy) begin
            prev_idx = 0;
            last_t1  = -1;
        end
        if (rst) acc_pend = 1'b0;
        if (!rst) begin
            if (inj_req && !prev_req) begin
                if (flt_idx == FW'(1)) begin
                    if (prev_idx != 0 && prev_idx != int'(NF)) seq_viol++;
                    o_vec.push_back(int'(test_vec));
                    if (last_t1 >= 0) o_len.push_back(cyc - last_t1);
                    last_t1 = cyc;
                end else begin
                    if (int'(flt_idx) != prev_idx + 1) seq_viol++;
                    if (low_run != 1) gap_viol++;
                end
                prev_idx = int'(flt_idx);
            end
            if (inj_req && prev_req && (test_vec !== prev_vec || flt_idx !== prev_fi)) stab_viol++;
            if (acc_pend) begin
                o_acc_det.push_back(int'(det_count));
                o_acc_cov.push_back(int'(coverage));
            end
            acc_pend = acc_valid;
            if (acc_valid) begin
                o_acc_vec.push_back(int'(acc_vec));
                o_acc_num.push_back(int'(acc_num));
            end
        end
        low_run  = inj_req ? 0 : low_run + 1;
        prev_req = inj_req;
        prev_vec = test_vec;
        prev_fi  = flt_idx;
    end

    // Trial-level reference: vector draw, detection sets, threshold, acceptance, stop rule
    task automatic model_run(input int md);
        logic [15:0] l;
        int e, t, det, cov, ct, nw, v;
        bit at [1:NF];
        bit hit [1:NF];
        m_vec.delete(); m_acc_vec.delete(); m_acc_num.delete();
        m_acc_det.delete(); m_acc_cov.delete();
        l = SEED; e = IE; t = 0; det = 0; cov = 0;
        at = '{default: 1'b0};
        forever begin
            l = (l >> 1) | (16'(l[0] ^ l[2] ^ l[3] ^ l[5]) << 15);
            v = int'(l) % 64;
            m_vec.push_back(v);
            t++; ct = 0; nw = 0;
            for (int f = 1; f <= int'(NF); f++) begin
                hit[f] = resp(md, VW'(v), f);
                if (hit[f]) begin
                    ct++;
                    if (!at[f]) nw++;
                end
            end
            e = (ct < e) ? e / 2 : (ct + e) / 2;
            if (ct >= e && nw > 0) begin
                det = 0;
                for (int f = 1; f <= int'(NF); f++) begin
                    if (hit[f]) at[f] = 1'b1;
                    det += int'(at[f]);
                end
                m_acc_vec.push_back(v); m_acc_num.push_back(t);
                m_acc_det.push_back(det); m_acc_cov.push_back(det * 100 / int'(NF));
            end
            cov = det * 100 / int'(NF);
            if (cov >= int'(CT) || t >= int'(UL)) break;
        end
        m_trials = t; m_det = det; m_cov = cov;
    endtask

    task automatic fill_table();
        for (int v = 0; v < 64; v++) mis_tab[v] = NF'($urandom) & NF'($urandom);
    endtask

    // Start a run and wait for done; optionally inject stray acks and start pulses
    task automatic do_run(input int tmo, input bit noisy, output bit ok);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < tmo; i++) begin
            if (done) begin ok = 1'b1; break; end
            stray = noisy && busy && !inj_req && ($urandom_range(2) == 0);
            start = noisy && busy && ($urandom_range(3) == 0);
            @(negedge clk);
        end
        stray = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, inj_req, acc_valid, test_vec, flt_idx} !== '0)
            $display("FAIL reset_held: ctl=%b vec=%0d idx=%0d required all zero",
                     {busy, done, inj_req, acc_valid}, test_vec, flt_idx);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done, inj_req, acc_valid} !== 4'b0)
            $display("FAIL reset_ctl: got %b required 0000", {busy, done, inj_req, acc_valid});
        else n_pass++;
        n_total++;
        if ({acc_vec, acc_num} !== '0)
            $display("FAIL reset_acc: vec=%0d num=%0d required 0", acc_vec, acc_num);
        else n_pass++;
        n_total++;
        if ({det_count, coverage, trials} !== '0)
            $display("FAIL reset_counts: det=%0d cov=%0d trials=%0d required 0", det_count, coverage, trials);
        else n_pass++;
    endtask

    task automatic test_all_mismatch();
        bit ok;
        int ab;
        mode = 0; lat = 0;
        model_run(0);
        ab = o_acc_vec.size();
        do_run(3000, 1'b0, ok);
        n_total++;
        if (!ok) $display("FAIL all_timeout: done=%b required 1", done); else n_pass++;
        n_total++;
        if (o_acc_vec.size() - ab != 1 || o_acc_num[ab] != 1 || o_acc_vec[ab] != m_acc_vec[0])
            $display("FAIL all_accept: count=%0d num=%0d required 1 accept num=1 vec=%0d",
                     o_acc_vec.size() - ab, (o_acc_num.size() > ab) ? o_acc_num[ab] : -1, m_acc_vec[0]);
        else n_pass++;
        n_total++;
        if (trials !== 8'd1 || det_count !== FW'(16) || coverage !== 7'd100 || busy !== 1'b0)
            $display("FAIL all_final: trials=%0d det=%0d cov=%0d busy=%b required 1/16/100/0",
                     trials, det_count, coverage, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (done !== 1'b1 || trials !== 8'(m_trials) || coverage !== 7'(m_cov))
            $display("FAIL all_hold: done=%b trials=%0d cov=%0d required 1/%0d/%0d",
                     done, trials, coverage, m_trials, m_cov);
        else n_pass++;
    endtask

    task automatic test_never();
        bit ok;
        int ab, lb;
        mode = 1; lat = 1;
        model_run(1);
        ab = o_acc_vec.size(); lb = o_len.size();
        do_run(3000, 1'b0, ok);
        n_total++;
        if (!ok || o_acc_vec.size() != ab)
            $display("FAIL never_accept: ok=%b accepts=%0d required done with 0", ok, o_acc_vec.size() - ab);
        else n_pass++;
        n_total++;
        if (trials !== 8'(m_trials) || trials !== 8'd13 || coverage !== 7'd0 || det_count !== '0)
            $display("FAIL never_final: trials=%0d cov=%0d det=%0d required 13/0/0", trials, coverage, det_count);
        else n_pass++;
        for (int i = lb; i < o_len.size(); i++) begin
            n_total++;
            if (o_len[i] != 1 + int'(NF) * 2 + int'(NF) - 1 + 2)
                $display("FAIL never_trial_len: got %0d required %0d", o_len[i], 1 + int'(NF) * 2 + int'(NF) + 1);
            else n_pass++;
        end
    endtask

    task automatic test_fault1();
        bit ok;
        int ab;
        mode = 2; lat = 0;
        model_run(2);
        ab = o_acc_vec.size();
        do_run(3000, 1'b0, ok);
        n_total++;
        if (!ok || o_acc_vec.size() - ab != 1)
            $display("FAIL f1_accepts: ok=%b count=%0d required 1", ok, o_acc_vec.size() - ab);
        else n_pass++;
        if (o_acc_vec.size() - ab == 1 && o_acc_det.size() > ab) begin
            n_total++;
            if (o_acc_num[ab] != 2 || o_acc_vec[ab] != m_vec[1] || o_acc_det[ab] != 1 || o_acc_cov[ab] != 6)
                $display("FAIL f1_accept: num=%0d vec=%0d det=%0d cov=%0d required 2/%0d/1/6",
                         o_acc_num[ab], o_acc_vec[ab], o_acc_det[ab], o_acc_cov[ab], m_vec[1]);
            else n_pass++;
        end
        n_total++;
        if (trials !== 8'd13 || trials !== 8'(m_trials) || coverage !== 7'd6)
            $display("FAIL f1_final: trials=%0d cov=%0d required 13/6", trials, coverage);
        else n_pass++;
    endtask

    task automatic test_latency();
        bit ok;
        int lb, sv, gv, qv, ab;
        mode = 2; lat = 3;
        model_run(2);
        lb = o_len.size(); ab = o_acc_vec.size();
        sv = stab_viol; gv = gap_viol; qv = seq_viol;
        do_run(4000, 1'b0, ok);
        n_total++;
        if (!ok || stab_viol != sv || gap_viol != gv || seq_viol != qv)
            $display("FAIL lat_protocol: ok=%b stab=%0d gap=%0d seq=%0d required done and 0/0/0",
                     ok, stab_viol - sv, gap_viol - gv, seq_viol - qv);
        else n_pass++;
        n_total++;
        if (o_len.size() - lb != int'(UL) - 1)
            $display("FAIL lat_trials_seen: got %0d required %0d", o_len.size() - lb, int'(UL) - 1);
        else n_pass++;
        for (int i = lb; i < o_len.size(); i++) begin
            n_total++;
            if (o_len[i] != 82) $display("FAIL lat_trial_len: got %0d required 82", o_len[i]);
            else n_pass++;
        end
        n_total++;
        if (o_acc_vec.size() - ab != m_acc_vec.size() || trials !== 8'(m_trials))
            $display("FAIL lat_result: accepts=%0d trials=%0d required %0d/%0d",
                     o_acc_vec.size() - ab, trials, m_acc_vec.size(), m_trials);
        else n_pass++;
    endtask

    task automatic test_noise();
        bit ok;
        int vb, ab, qv, gv;
        fill_table();
        mode = 3; lat = $urandom_range(2);
        model_run(3);
        vb = o_vec.size(); ab = o_acc_vec.size(); qv = seq_viol; gv = gap_viol;
        do_run(4000, 1'b1, ok);
        n_total++;
        if (!ok || seq_viol != qv || gap_viol != gv || o_vec.size() - vb != m_vec.size())
            $display("FAIL noise_flow: ok=%b seq=%0d gap=%0d trials_seen=%0d required done 0 0 %0d",
                     ok, seq_viol - qv, gap_viol - gv, o_vec.size() - vb, m_vec.size());
        else n_pass++;
        for (int i = 0; i < m_vec.size() && vb + i < o_vec.size(); i++) begin
            n_total++;
            if (o_vec[vb + i] != m_vec[i])
                $display("FAIL noise_vec[%0d]: got %0d required %0d", i, o_vec[vb + i], m_vec[i]);
            else n_pass++;
        end
        n_total++;
        if (o_acc_vec.size() - ab != m_acc_vec.size())
            $display("FAIL noise_accepts: got %0d required %0d", o_acc_vec.size() - ab, m_acc_vec.size());
        else n_pass++;
        for (int i = 0; i < m_acc_vec.size() && ab + i < o_acc_det.size(); i++) begin
            n_total++;
            if (o_acc_vec[ab + i] != m_acc_vec[i] || o_acc_num[ab + i] != m_acc_num[i] ||
                o_acc_det[ab + i] != m_acc_det[i] || o_acc_cov[ab + i] != m_acc_cov[i])
                $display("FAIL noise_acc[%0d]: vec/num/det/cov %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", i,
                         o_acc_vec[ab + i], o_acc_num[ab + i], o_acc_det[ab + i], o_acc_cov[ab + i],
                         m_acc_vec[i], m_acc_num[i], m_acc_det[i], m_acc_cov[i]);
            else n_pass++;
        end
        n_total++;
        if (trials !== 8'(m_trials) || det_count !== FW'(m_det) || coverage !== 7'(m_cov))
            $display("FAIL noise_final: trials=%0d det=%0d cov=%0d required %0d/%0d/%0d",
                     trials, det_count, coverage, m_trials, m_det, m_cov);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit ok, found;
        int vb;
        fill_table();
        mode = 3; lat = 2;
        model_run(3);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (inj_req && int'(flt_idx) >= 3) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_total++;
        if (!found) $display("FAIL rst_reach_req: inj_req=%b idx=%0d required req at idx>=3", inj_req, flt_idx);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (inj_req !== 1'b0 || busy !== 1'b0 || flt_idx !== '0 || test_vec !== '0 || trials !== '0)
            $display("FAIL rst_async: req=%b busy=%b idx=%0d vec=%0d trials=%0d required all 0",
                     inj_req, busy, flt_idx, test_vec, trials);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        vb = o_vec.size();
        do_run(4000, 1'b0, ok);
        n_total++;
        if (!ok || o_vec.size() - vb != m_vec.size())
            $display("FAIL rst_rerun: ok=%b trials_seen=%0d required %0d", ok, o_vec.size() - vb, m_vec.size());
        else n_pass++;
        for (int i = 0; i < m_vec.size() && vb + i < o_vec.size(); i++) begin
            n_total++;
            if (o_vec[vb + i] != m_vec[i])
                $display("FAIL rst_vec[%0d]: got %0d required %0d", i, o_vec[vb + i], m_vec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int vb, ab;
        mode = 0; lat = 0;
        do_run(3000, 1'b0, ok);
        fill_table();
        mode = 3; lat = 1;
        model_run(3);
        vb = o_vec.size(); ab = o_acc_vec.size();
        do_run(4000, 1'b0, ok);
        n_total++;
        if (!ok || o_vec.size() - vb != m_vec.size() || o_acc_vec.size() - ab != m_acc_vec.size())
            $display("FAIL b2b_flow: ok=%b trials_seen=%0d accepts=%0d required %0d/%0d",
                     ok, o_vec.size() - vb, o_acc_vec.size() - ab, m_vec.size(), m_acc_vec.size());
        else n_pass++;
        n_total++;
        if (m_vec.size() > 0 && o_vec.size() > vb && o_vec[vb] != m_vec[0])
            $display("FAIL b2b_first_vec: got %0d required %0d", o_vec[vb], m_vec[0]);
        else n_pass++;
        for (int i = 0; i < m_acc_vec.size() && ab + i < o_acc_num.size(); i++) begin
            n_total++;
            if (o_acc_vec[ab + i] != m_acc_vec[i] || o_acc_num[ab + i] != m_acc_num[i])
                $display("FAIL b2b_acc[%0d]: vec/num %0d/%0d required %0d/%0d", i,
                         o_acc_vec[ab + i], o_acc_num[ab + i], m_acc_vec[i], m_acc_num[i]);
            else n_pass++;
        end
        n_total++;
        if (trials !== 8'(m_trials) || det_count !== FW'(m_det) || coverage !== 7'(m_cov))
            $display("FAIL b2b_final: trials=%0d det=%0d cov=%0d required %0d/%0d/%0d",
                     trials, det_count, coverage, m_trials, m_det, m_cov);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_mismatch();
        test_never();
        test_fault1();
        test_latency();
        test_noise();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adaptive_rtg_controller.md
# adaptive_rtg_controller

Synthesizable sequencer for adjustable random test generation. It draws pseudo-random test vectors from an internal LFSR and walks each vector through the collapsed fault list via a request/acknowledge handshake with an external fault-simulation datapath (good/faulty CUT pair plus injector). It keeps an adaptive detection threshold and accepts a vector only if it meets the threshold and detects at least one new fault. It stops when the coverage target or the trial limit is reached.

## Interface
- NUM_FAULTS, 16, collapsed faults, indexed 1..NUM_FAULTS
- VEC_W, 6, test-vector width (≤ 16)
- INIT_EXP, 5, initial expected-detection count
- UT_LIMIT, 13, maximum trials (1..255)
- COV_TARGET, 95, coverage stop threshold, percent
- LFSR_SEED, 16'hACE1, nonzero LFSR reload value
- FIDX_W, 5, index/count width, ≥ clog2(NUM_FAULTS+1)
- clk  in  1  clock; one clock for the whole block
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin a run; sampled only in IDLE or DONE
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- test_vec  out  VEC_W  vector applied to both CUT copies
- flt_idx  out  FIDX_W  fault to inject, 1..NUM_FAULTS
- inj_req  out  1  evaluate test_vec with fault flt_idx
- inj_ack  in  1  evaluation complete; mismatch valid this cycle
- mismatch  in  1  good and faulty outputs differ
- acc_valid  out  1  one-cycle pulse: vector accepted
- acc_vec  out  VEC_W  accepted vector, valid with acc_valid
- acc_num  out  8  trial number of the accepted vector
- det_count  out  FIDX_W  cumulative detected faults
- coverage  out  7  floor(100*det_count/NUM_FAULTS)
- trials  out  8  trials executed in this run

## Operation
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Loaded with LFSR_SEED on reset and on every accepted start. Advances once per GEN. test_vec = low VEC_W bits after the advance.
- State storage: ct_list[1..N] (current trial), at_list[1..N] (accumulated), ct_cnt, new_cnt, exp (FIDX_W+1 bits), ut (8 bits).
- IDLE: on start, clear at_list, det_count, coverage, trials, ut; set exp=INIT_EXP; reload LFSR; assert busy; go to GEN.
- GEN: advance LFSR, update test_vec, ut++, trials++; clear ct_list, ct_cnt, new_cnt; set flt_idx=1; go to REQ.
- REQ: hold inj_req=1 and keep test_vec and flt_idx stable until inj_ack=1.
  - On the ack cycle, if mismatch=1: set ct_list[flt_idx], ct_cnt++, and new_cnt++ if at_list[flt_idx]=0.
  - If flt_idx=NUM_FAULTS, go to UPDATE; otherwise go to GAP.
- GAP: inj_req=0 for exactly one cycle, flt_idx++, go to REQ.
- UPDATE:
  - exp_n = (ct_cnt < exp) ? exp>>1 : (ct_cnt+exp)>>1; store exp=exp_n.
  - Accept iff ct_cnt ≥ exp_n AND new_cnt > 0. The compare uses the updated exp.
  - On accept: at_list |= ct_list; det_count = popcount(at_list); pulse acc_valid with acc_vec=test_vec and acc_num=ut.
  - Go to CHECK.
- CHECK:
  - coverage = floor(100*det_count/NUM_FAULTS), registered this cycle.
  - If coverage ≥ COV_TARGET or ut ≥ UT_LIMIT, go to DONE; otherwise go to GEN.
- DONE: busy=0, done=1. All result outputs hold. start restarts as from IDLE, including the LFSR reload.

## Timing
- Reset values: busy=0, done=0, inj_req=0, acc_valid=0, test_vec=0, flt_idx=0, acc_vec=0, acc_num=0, det_count=0, coverage=0, trials=0. State=IDLE, LFSR=LFSR_SEED.
- Reset mid-run, any state: all outputs take reset values immediately, without waiting for a clock edge. A pending inj_ack is discarded.
- inj_req rises the cycle after GEN or GAP. It falls the cycle after the ack cycle.
- Ack latency L ≥ 0 cycles after inj_req rises. inj_ack combinationally high together with inj_req counts as L=0.
- inj_ack outside REQ is ignored. start while busy=1 is ignored.
- Trial length = 1 (GEN) + NUM_FAULTS·(L+1) + (NUM_FAULTS−1) (GAP) + 2 (UPDATE, CHECK) cycles.
- acc_valid is high exactly the UPDATE→CHECK cycle. coverage and det_count are valid the cycle after acc_valid.
- With NUM_FAULTS=16: 15 detected gives 93%, 16 gives 100%, so the default target requires full detection.

## Test plan
- Reset during REQ with inj_req=1 -> inj_req=0 and busy=0 before the next clk edge. A following start reproduces the identical test_vec sequence starting from the seeded LFSR.
- Responder returns mismatch=1 for all faults -> trial 1: ct=16, exp=(16+5)/2=10, accepted. acc_num=1, det_count=16, coverage=100, done with trials=1.
- Responder never mismatches -> exp goes 5→2→1→0→0…; no acc_valid. done after trials=13, coverage=0.
- Mismatch only on fault 1, every trial:
  - Trial 1 rejected (exp=2).
  - Trial 2 accepted with acc_num=2, det_count=1, coverage=6.
  - Trials 3–13 rejected because new_cnt=0.
  - done with trials=13.
- inj_ack delayed 3 cycles per fault -> inj_req, flt_idx and test_vec stable throughout each wait. One inj_req=0 cycle between faults. flt_idx steps 1..16. Trial length = 1+64+15+2 = 82 cycles.
- start pulsed while busy, and inj_ack pulsed in GEN/GAP -> no effect on state, counts, or flt_idx sequence.
